// File: rtl/pmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// pmem_arbiter_if
//   Bundles every bus-side signal of the physical-memory arbiter: the I-cache
//   fill port, the D-cache fill/writeback port, the physical-memory command
//   port and the conflict perf pulse.
//
//   Modports:
//     slave  - the arbiter itself (takes cache requests and memory responses,
//              drives memory commands and cache responses)
//     master - the environment around it (caches + physical memory)
//
//   Signals (widths from ADDR_W / LINE_W):
//     i_pmem_read, i_pmem_address            I-side request
//     i_pmem_rdata, i_pmem_resp              I-side response
//     d_pmem_read, d_pmem_write,
//     d_pmem_address, d_pmem_wdata           D-side request
//     d_pmem_rdata, d_pmem_resp              D-side response
//     pmem_read, pmem_write,
//     pmem_address, pmem_wdata               command to memory
//     pmem_rdata, pmem_resp                  memory response
//     conflict_inc                           both sides requesting in IDLE
// ----------------------------------------------------------------------------
interface pmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;

    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    logic              conflict_inc;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output i_pmem_rdata, i_pmem_resp,
        output d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        output conflict_inc
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  i_pmem_rdata, i_pmem_resp,
        input  d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  conflict_inc
    );
endinterface

// File: rtl/pmem_arbiter.sv
// ----------------------------------------------------------------------------
// pmem_arbiter
//   Shares one physical-memory port between the I-cache fill path and the
//   D-cache fill/writeback path. One side is granted at a time; the memory
//   command is decoded purely from the FSM state, and pmem_resp/pmem_rdata are
//   routed back to the granted side only. Every transaction is followed by one
//   IDLE turnaround cycle, so a late pmem_resp can never complete a new grant.
//
//   Ports:
//     clk    - clock, all state on the rising edge
//     rst_n  - asynchronous active-low reset (state -> IDLE, last grant -> I)
//     bus    - pmem_arbiter_if.slave, all cache/memory handshake signals
//
//   Build option:
//     ARB_ROUND_ROBIN_EN - when defined, a conflict grants the side opposite
//                          the previous grant (first conflict after reset goes
//                          to D). When undefined, D always wins conflicts.
// ----------------------------------------------------------------------------
module pmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic           clk,
    input  logic           rst_n,
    pmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic i_req, d_req;
    logic pick_d;        // conflict resolution: 1 -> grant D

    logic [ADDR_W-1:0] addr_mux;
    logic [LINE_W-1:0] wdata_mux;

    assign i_req = bus.i_pmem_read;
    assign d_req = bus.d_pmem_read | bus.d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    grant_e last_grant_q, last_grant_d;

    assign pick_d = (last_grant_q == GRANT_I);

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && state_d == D_BUSY)
            last_grant_d = GRANT_D;
        else if (state_q == IDLE && state_d == I_BUSY)
            last_grant_d = GRANT_I;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant_q <= GRANT_I;
        else
            last_grant_q <= last_grant_d;
    end
`else
    assign pick_d = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its inputs, independent of block order.
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and conflict pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d          = state_q;
        bus.conflict_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.conflict_inc = i_req & d_req;
                if (i_req && d_req)
                    state_d = pick_d ? D_BUSY : I_BUSY;
                else if (d_req)
                    state_d = D_BUSY;
                else if (i_req)
                    state_d = I_BUSY;
            end
            I_BUSY, D_BUSY: begin
                // A requester dropping its request mid-transaction is illegal;
                // only pmem_resp ends the grant.
                if (bus.pmem_resp)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory command and response routing, decoded from state only.
    always_comb begin
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        addr_mux         = '0;
        wdata_mux        = '0;
        bus.i_pmem_resp  = 1'b0;
        bus.i_pmem_rdata = '0;
        bus.d_pmem_resp  = 1'b0;
        bus.d_pmem_rdata = '0;
        unique case (state_q)
            I_BUSY: begin
                bus.pmem_read    = 1'b1;
                addr_mux         = bus.i_pmem_address;
                bus.i_pmem_resp  = bus.pmem_resp;
                bus.i_pmem_rdata = bus.pmem_rdata;
            end
            D_BUSY: begin
                // Read and write together is treated as a writeback.
                bus.pmem_read    = bus.d_pmem_read & ~bus.d_pmem_write;
                bus.pmem_write   = bus.d_pmem_write;
                addr_mux         = bus.d_pmem_address;
                wdata_mux        = bus.d_pmem_wdata;
                bus.d_pmem_resp  = bus.pmem_resp;
                bus.d_pmem_rdata = bus.pmem_rdata;
            end
            default: ;  // IDLE: command low, any pmem_resp is ignored
        endcase
    end

    assign bus.pmem_address = addr_mux;
    assign bus.pmem_wdata   = wdata_mux;

endmodule

// File: tb/tb_pmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_pmem_arbiter
//   Directed scenarios (single I fill, D writeback, read+write collision,
//   reset mid-transaction, arbitration on conflict) followed by a randomized
//   phase in which behavioural caches and a memory with random latency drive
//   the arbiter. Expected outputs come from a transaction-level model of who
//   owns the memory port.
// ----------------------------------------------------------------------------
module tb_pmem_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs are then driven 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.i_pmem_read    = 1'b0;
        bus.i_pmem_address = '0;
        bus.d_pmem_read    = 1'b0;
        bus.d_pmem_write   = 1'b0;
        bus.d_pmem_address = '0;
        bus.d_pmem_wdata   = '0;
        bus.pmem_rdata     = '0;
        bus.pmem_resp      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Reference model: which side owns the memory port this cycle.
    typedef enum int { M_NONE, M_I, M_D } owner_t;

    owner_t            m_owner;
    bit                m_last_d;
    bit                pick_d;
    bit                p_i, p_d, p_resp, i_done, d_done;
    bit                i_act, d_act;
    int                d_kind;       // 0 read, 1 write, 2 read+write
    int                mem_lat;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] d_wdata, rdata;
    bit                resp;
    bit                d_rd, d_wr;
    bit                e_rd, e_wr, e_i_resp, e_d_resp, e_conf;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wdata, e_i_rdata, e_d_rdata;

    localparam logic [LINE_W-1:0] LINE_I  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [LINE_W-1:0] LINE_D  = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1357_9BDF;
    localparam logic [LINE_W-1:0] LINE_A5 = {16{8'hA5}};

    initial begin
        idle_inputs();

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #2;
        check("rst_pmem_read",  bus.pmem_read,    1'b0);
        check("rst_pmem_write", bus.pmem_write,   1'b0);
        check("rst_i_resp",     bus.i_pmem_resp,  1'b0);
        check("rst_d_resp",     bus.d_pmem_resp,  1'b0);
        check("rst_conflict",   bus.conflict_inc, 1'b0);
        rst_n = 1'b1;

        // ---------------- I read 0x1230, resp on third busy cycle ----------------
        step();
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h1230;
        #1;
        check("t1_idle_read", bus.pmem_read,    1'b0);
        check("t1_idle_conf", bus.conflict_inc, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 3) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = LINE_I;
            end
            #1;
            check("t1_read",    bus.pmem_read,    1'b1);
            check("t1_write",   bus.pmem_write,   1'b0);
            check("t1_addr",    bus.pmem_address, 16'h1230);
            check("t1_i_resp",  bus.i_pmem_resp,  (c == 3));
            check("t1_d_resp",  bus.d_pmem_resp,  1'b0);
            check("t1_d_rdata", bus.d_pmem_rdata, '0);
        end
        check("t1_i_rdata", bus.i_pmem_rdata, LINE_I);
        step();
        bus.i_pmem_read = 1'b0;
        bus.pmem_resp   = 1'b0;
        #1;
        check("t1_turn_read",  bus.pmem_read,    1'b0);
        check("t1_turn_iresp", bus.i_pmem_resp,  1'b0);
        check("t1_turn_irdat", bus.i_pmem_rdata, '0);

        // ---------------- D write 0x4000 ----------------
        bus.d_pmem_write   = 1'b1;
        bus.d_pmem_address = 16'h4000;
        bus.d_pmem_wdata   = LINE_A5;
        #1;
        check("t2_idle_write", bus.pmem_write, 1'b0);
        check("t2_idle_wdata", bus.pmem_wdata, '0);
        step();
        bus.pmem_resp = 1'b1;
        #1;
        check("t2_write",  bus.pmem_write,   1'b1);
        check("t2_read",   bus.pmem_read,    1'b0);
        check("t2_addr",   bus.pmem_address, 16'h4000);
        check("t2_wdata",  bus.pmem_wdata,   LINE_A5);
        check("t2_d_resp", bus.d_pmem_resp,  1'b1);
        check("t2_i_resp", bus.i_pmem_resp,  1'b0);
        step();
        bus.d_pmem_write = 1'b0;
        bus.pmem_resp    = 1'b0;
        #1;
        check("t2_after_write", bus.pmem_write,  1'b0);
        check("t2_after_dresp", bus.d_pmem_resp, 1'b0);

        // ---------------- D read and write together -> write ----------------
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_write   = 1'b1;
        bus.d_pmem_address = 16'h5550;
        step();
        bus.pmem_resp = 1'b1;
        #1;
        check("t3_write", bus.pmem_write, 1'b1);
        check("t3_read",  bus.pmem_read,  1'b0);
        step();
        bus.d_pmem_read  = 1'b0;
        bus.d_pmem_write = 1'b0;
        bus.pmem_resp    = 1'b0;

        // ---------------- reset in the middle of D_BUSY ----------------
        bus.d_pmem_write   = 1'b1;
        bus.d_pmem_address = 16'h6000;
        step();
        #1;
        check("t4_busy_write", bus.pmem_write, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t4_rst_write", bus.pmem_write,  1'b0);
        check("t4_rst_dresp", bus.d_pmem_resp, 1'b0);
        bus.d_pmem_write = 1'b0;
        step();
        rst_n         = 1'b1;
        bus.pmem_resp = 1'b1;   // late response from the abandoned write
        #1;
        check("t4_late_dresp", bus.d_pmem_resp, 1'b0);
        check("t4_late_iresp", bus.i_pmem_resp, 1'b0);
        check("t4_late_write", bus.pmem_write,  1'b0);
        step();
        bus.pmem_resp = 1'b0;
        #1;
        check("t4_idle_read", bus.pmem_read, 1'b0);

        // ---------------- conflict arbitration ----------------
        do_reset();
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h1100;
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_address = 16'h2200;
`ifndef ARB_ROUND_ROBIN_EN
        #1;
        check("t5_conflict", bus.conflict_inc, 1'b1);
        step();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = LINE_D;
        #1;
        check("t5_d_addr",   bus.pmem_address, 16'h2200);
        check("t5_d_resp",   bus.d_pmem_resp,  1'b1);
        check("t5_d_rdata",  bus.d_pmem_rdata, LINE_D);
        check("t5_i_resp0",  bus.i_pmem_resp,  1'b0);
        check("t5_i_rdata0", bus.i_pmem_rdata, '0);
        check("t5_busy_cnf", bus.conflict_inc, 1'b0);
        step();
        bus.d_pmem_read = 1'b0;
        bus.pmem_resp   = 1'b0;
        #1;
        check("t5_gap_read", bus.pmem_read,    1'b0);
        check("t5_gap_conf", bus.conflict_inc, 1'b0);
        step();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = LINE_I;
        #1;
        check("t5_i_addr",  bus.pmem_address, 16'h1100);
        check("t5_i_resp",  bus.i_pmem_resp,  1'b1);
        check("t5_i_rdata", bus.i_pmem_rdata, LINE_I);
        step();
        bus.i_pmem_read = 1'b0;
        bus.pmem_resp   = 1'b0;
`else
        // Both sides keep requesting: grants must alternate D, I, D, I, D, I.
        for (int g = 0; g < 6; g++) begin
            #1;
            check("t5_rr_conflict", bus.conflict_inc, 1'b1);
            step();
            bus.pmem_resp = 1'b1;
            #1;
            check("t5_rr_addr", bus.pmem_address, (g % 2 == 0) ? 16'h2200 : 16'h1100);
            check("t5_rr_read", bus.pmem_read, 1'b1);
            step();
            bus.pmem_resp = 1'b0;
        end
        bus.i_pmem_read = 1'b0;
        bus.d_pmem_read = 1'b0;
        step();
`endif

        // ---------------- randomized traffic against the model ----------------
        do_reset();
        m_owner  = M_NONE;
        m_last_d = 1'b0;
        p_i = 0; p_d = 0; p_resp = 0; i_done = 0; d_done = 0;
        i_act = 0; d_act = 0; d_kind = 0; mem_lat = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;

        for (int cyc = 0; cyc < 500; cyc++) begin
            @(posedge clk);
            // Ownership changes decided from what was presented before the edge.
            if (m_owner == M_NONE) begin
                if (p_i && p_d) begin
`ifdef ARB_ROUND_ROBIN_EN
                    pick_d = !m_last_d;
`else
                    pick_d = 1'b1;
`endif
                    m_owner = pick_d ? M_D : M_I;
                end else if (p_d) begin
                    m_owner = M_D;
                end else if (p_i) begin
                    m_owner = M_I;
                end
                if (m_owner != M_NONE) begin
                    m_last_d = (m_owner == M_D);
                    mem_lat  = $urandom_range(0, 3);
                end
            end else if (p_resp) begin
                m_owner = M_NONE;
            end
            #2;

            // Caches: retire a completed request, maybe start a new one.
            if (i_done) i_act = 0;
            if (d_done) d_act = 0;
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act  = 1;
                i_addr = ADDR_W'($urandom);
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act   = 1;
                d_kind  = $urandom_range(0, 2);
                d_addr  = ADDR_W'($urandom);
                d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            d_rd = d_act && (d_kind != 1);
            d_wr = d_act && (d_kind != 0);

            // Memory: respond after the chosen latency; stray pulses when idle.
            if (m_owner != M_NONE) begin
                resp = (mem_lat == 0);
                if (mem_lat > 0) mem_lat--;
            end else begin
                resp = ($urandom_range(0, 7) == 0);
            end
            rdata = {$urandom, $urandom, $urandom, $urandom};

            bus.i_pmem_read    = i_act;
            bus.i_pmem_address = i_addr;
            bus.d_pmem_read    = d_rd;
            bus.d_pmem_write   = d_wr;
            bus.d_pmem_address = d_addr;
            bus.d_pmem_wdata   = d_wdata;
            bus.pmem_resp      = resp;
            bus.pmem_rdata     = rdata;
            #1;

            e_rd      = (m_owner == M_I) || (m_owner == M_D && d_rd && !d_wr);
            e_wr      = (m_owner == M_D) && d_wr;
            e_addr    = (m_owner == M_I) ? i_addr : d_addr;
            e_wdata   = (m_owner == M_D) ? d_wdata : '0;
            e_i_resp  = (m_owner == M_I) && resp;
            e_d_resp  = (m_owner == M_D) && resp;
            e_i_rdata = (m_owner == M_I) ? rdata : '0;
            e_d_rdata = (m_owner == M_D) ? rdata : '0;
            e_conf    = (m_owner == M_NONE) && i_act && d_act;

            check("rnd_pmem_read",  bus.pmem_read,    e_rd);
            check("rnd_pmem_write", bus.pmem_write,   e_wr);
            if (m_owner != M_NONE)
                check("rnd_pmem_addr", bus.pmem_address, e_addr);
            check("rnd_pmem_wdata", bus.pmem_wdata,   e_wdata);
            check("rnd_i_resp",     bus.i_pmem_resp,  e_i_resp);
            check("rnd_d_resp",     bus.d_pmem_resp,  e_d_resp);
            check("rnd_i_rdata",    bus.i_pmem_rdata, e_i_rdata);
            check("rnd_d_rdata",    bus.d_pmem_rdata, e_d_rdata);
            check("rnd_conflict",   bus.conflict_inc, e_conf);

            p_i    = i_act;
            p_d    = d_act;
            p_resp = resp;
            i_done = e_i_resp;
            d_done = e_d_resp;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
